// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - multi-channel input mux with manual select and timed auto-scan
// Build option: define SCAN_MUX_HOLD_EN to keep a disabled channel's dout at its last value.
module scan_mux #(
    parameter int CH    = 2,
    parameter int SEL_W = 2,
    parameter int DW    = 1,
    parameter int DWELL = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CH-1:0]               en_n,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    input  logic [CH*(2**SEL_W)*DW-1:0] din,
    output logic [CH*DW-1:0]            dout,
    output logic [CH-1:0]               valid,
    output logic [SEL_W-1:0]            cur_sel,
    output logic                        scan_wrap
);

    localparam int NIN = 2**SEL_W;
    localparam int CW  = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_SCAN   = 2'd1,
        S_PAUSE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    dwell_q, dwell_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [CH*DW-1:0] dout_q, dout_d;
    logic [CH-1:0]    valid_q, valid_d;
    logic [SEL_W-1:0] eff_idx;
    logic             any_en;

    assign any_en = |(~en_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MANUAL: if (mode) state_d = any_en ? S_SCAN : S_PAUSE;
            S_SCAN: begin
                if (!mode)        state_d = S_MANUAL;
                else if (!any_en) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (!mode)       state_d = S_MANUAL;
                else if (any_en) state_d = S_SCAN;
            end
            default: state_d = S_MANUAL;
        endcase
    end

    // Counters run only while scanning continues; MANUAL keeps them cleared so a
    // later SCAN entry starts at 0, while PAUSE leaves them untouched for resume.
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        if (state_q == S_MANUAL) begin
            idx_d   = '0;
            dwell_d = '0;
        end else if (state_q == S_SCAN && state_d == S_SCAN) begin
            if (dwell_q == CW'(DWELL - 1)) begin
                dwell_d = '0;
                idx_d   = idx_q + SEL_W'(1);
                wrap_d  = (idx_q == SEL_W'(NIN - 1));
            end else begin
                dwell_d = dwell_q + CW'(1);
            end
        end
    end

    assign eff_idx = (state_q == S_MANUAL) ? sel : idx_q;

    always_comb begin
        cur_d   = eff_idx;
        dout_d  = '0;
        valid_d = ~en_n;
        for (int c = 0; c < CH; c++) begin
            if (!en_n[c]) begin
                for (int i = 0; i < NIN; i++) begin
                    if (eff_idx == SEL_W'(i)) dout_d[c*DW +: DW] = din[(c*NIN + i)*DW +: DW];
                end
            end else begin
`ifdef SCAN_MUX_HOLD_EN
                dout_d[c*DW +: DW] = dout_q[c*DW +: DW];
`else
                dout_d[c*DW +: DW] = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            cur_q   <= '0;
            dout_q  <= '0;
            valid_q <= '0;
        end else begin
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            cur_q   <= cur_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign cur_sel   = cur_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - self-checking bench for scan_mux (default build and parameter sweep)
module tb_scan_mux;

    localparam int CH = 2, SEL_W = 2, DW = 1, DWELL = 4, NIN = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [CH-1:0]        en_n;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [CH*NIN*DW-1:0] din;
    logic [CH*DW-1:0]     dout;
    logic [CH-1:0]        valid;
    logic [SEL_W-1:0]     cur_sel;
    logic                 scan_wrap;

    logic [3:0]   en_n_s;
    logic         mode_s;
    logic [2:0]   sel_s;
    logic [255:0] din_s;
    logic [31:0]  dout_s;
    logic [3:0]   valid_s;
    logic [2:0]   cur_sel_s;
    logic         wrap_s;

    scan_mux u_dut (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel), .din(din),
        .dout(dout), .valid(valid), .cur_sel(cur_sel), .scan_wrap(scan_wrap)
    );

    scan_mux #(.CH(4), .SEL_W(3), .DW(8), .DWELL(1)) u_sweep (
        .clk(clk), .rst_n(rst_n), .en_n(en_n_s), .mode(mode_s), .sel(sel_s), .din(din_s),
        .dout(dout_s), .valid(valid_s), .cur_sel(cur_sel_s), .scan_wrap(wrap_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: state is implied by the last sampled mode/en_n; scan position is a
    // single cycle count over NIN*DWELL slots, index = position / DWELL.
    bit         m_nm, m_scan;
    int         pos;
    logic [1:0] m_dout;
    logic [1:0] e_dout, e_valid, e_cur;
    logic       e_wrap;

    task automatic model_reset();
        m_nm = 0; m_scan = 0; pos = 0; m_dout = '0;
    endtask

    task automatic clock_model();
        int eff;
        bit nxt_scan;
        eff = m_nm ? pos / DWELL : int'(sel);
        e_dout = '0;
        for (int c = 0; c < CH; c++) begin
            if (!en_n[c]) e_dout[c] = din[c*NIN + eff];
`ifdef SCAN_MUX_HOLD_EN
            else e_dout[c] = m_dout[c];
`endif
        end
        e_valid = ~en_n;
        e_cur   = 2'(eff);
        e_wrap  = 1'b0;
        nxt_scan = mode && (en_n != 2'b11);
        if (!mode) pos = 0;
        else if (m_scan && nxt_scan) begin
            pos++;
            if (pos == NIN*DWELL) begin
                pos = 0;
                e_wrap = 1'b1;
            end
        end
        m_nm = mode; m_scan = nxt_scan; m_dout = e_dout;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_cur_sel", cur_sel, 0);
        chk("rst_wrap", scan_wrap, 0);
        chk("rst_sweep_valid", valid_s, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] en_n;
        logic [1:0] sel;
        logic [7:0] din;
        logic [1:0] exp_dout;
        logic [1:0] exp_valid;
        logic [1:0] exp_cur;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int wraps;
        rst_n = 1'b0; en_n = 2'b11; mode = 1'b0; sel = '0; din = '0;
        en_n_s = 4'hf; mode_s = 1'b0; sel_s = '0; din_s = '0;

        // Manual mode; disabled channels always had dout 0 beforehand so both builds agree.
        vecs[0] = '{2'b00, 2'd2, 8'b1011_0100, 2'b01, 2'b11, 2'd2};
        vecs[1] = '{2'b00, 2'd0, 8'b1011_0100, 2'b10, 2'b11, 2'd0};
        vecs[2] = '{2'b01, 2'd3, 8'b0011_0100, 2'b00, 2'b10, 2'd3};
        vecs[3] = '{2'b10, 2'd1, 8'b0000_0010, 2'b01, 2'b01, 2'd1};
        vecs[4] = '{2'b00, 2'd2, 8'b0100_0000, 2'b10, 2'b11, 2'd2};
        vecs[5] = '{2'b00, 2'd3, 8'b1111_1111, 2'b11, 2'b11, 2'd3};
        vecs[6] = '{2'b00, 2'd1, 8'b0000_0000, 2'b00, 2'b11, 2'd1};
        vecs[7] = '{2'b11, 2'd0, 8'b1111_1111, 2'b00, 2'b00, 2'd0};

        do_reset();
        for (int v = 0; v < 8; v++) begin
            en_n = vecs[v].en_n; sel = vecs[v].sel; din = vecs[v].din; mode = 1'b0;
            clock_model();
            chk($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
            chk($sformatf("vec%0d_valid", v), valid, vecs[v].exp_valid);
            chk($sformatf("vec%0d_cur_sel", v), cur_sel, vecs[v].exp_cur);
            chk($sformatf("vec%0d_wrap", v), scan_wrap, 0);
        end

        // Scan with ch0 only: index holds DWELL cycles each, one wrap pulse after 16.
        do_reset();
        mode = 1'b0; sel = 2'd1; en_n = 2'b10; din = 8'b0000_1010;
        clock_model();
        mode = 1'b1;
        clock_model();
        wraps = 0;
        for (int k = 1; k <= 17; k++) begin
            clock_model();
            chk($sformatf("scan_cur_sel_k%0d", k), cur_sel, ((k - 1) / 4) % 4);
            chk($sformatf("scan_wrap_k%0d", k), scan_wrap, (k == 16));
            chk($sformatf("scan_dout_k%0d", k), dout[0], (((k - 1) / 4) % 4) & 1);
            if (scan_wrap) wraps++;
        end
        chk("scan_valid", valid, 2'b01);
        chk("scan_wrap_count", wraps, 1);

        // Pause at index 2 / dwell 1, then resume the remaining dwell slots.
        do_reset();
        mode = 1'b1; en_n = 2'b00; din = '0;
        clock_model();
        for (int k = 1; k <= 9; k++) clock_model();
        chk("pause_pre_cur_sel", cur_sel, 2);
        en_n = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            clock_model();
            chk($sformatf("pause_cur_sel_k%0d", k), cur_sel, 2);
            chk($sformatf("pause_valid_k%0d", k), valid, 0);
            chk($sformatf("pause_wrap_k%0d", k), scan_wrap, 0);
        end
        en_n = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            clock_model();
            chk($sformatf("resume_cur_sel_k%0d", k), cur_sel, (k <= 4) ? 2 : 3);
        end

        // Disabled channel output in each build.
        do_reset();
        mode = 1'b0; sel = 2'd0; en_n = 2'b00; din = 8'b0000_0001;
        clock_model();
        chk("dis_pre_dout0", dout[0], 1);
        en_n = 2'b01;
        clock_model();
`ifdef SCAN_MUX_HOLD_EN
        chk("dis_dout0_hold", dout[0], 1);
`else
        chk("dis_dout0_zero", dout[0], 0);
`endif
        chk("dis_valid0", valid[0], 0);

        // Asynchronous reset in the middle of a scan.
        do_reset();
        mode = 1'b1; en_n = 2'b00; din = 8'hff;
        clock_model();
        for (int k = 1; k <= 13; k++) clock_model();
        chk("mid_pre_cur_sel", cur_sel, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_cur_sel", cur_sel, 0);
        chk("mid_rst_wrap", scan_wrap, 0);
        model_reset();
        mode = 1'b0; sel = 2'd1; en_n = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        clock_model();
        chk("mid_post_cur_sel", cur_sel, 1);
        chk("mid_post_valid", valid, 2'b11);

        // Random stimulus against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            mode = ($urandom_range(0, 9) != 0);
            en_n = ($urandom_range(0, 4) == 0) ? 2'b11 : 2'($urandom);
            sel  = 2'($urandom);
            din  = 8'($urandom);
            clock_model();
            chk("rnd_dout", dout, e_dout);
            chk("rnd_valid", valid, e_valid);
            chk("rnd_cur_sel", cur_sel, e_cur);
            chk("rnd_wrap", scan_wrap, e_wrap);
        end

        // Parameter sweep instance: DWELL=1 advances every cycle.
        do_reset();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 8; i++)
                din_s[(c*8 + i)*8 +: 8] = 8'(c*16 + i);
        en_n_s = 4'h0; mode_s = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep_ch3_k%0d", k), dout_s[31:24], 8'h30 + 8'((k - 1) % 8));
            chk($sformatf("sweep_ch0_k%0d", k), dout_s[7:0], 8'((k - 1) % 8));
            chk($sformatf("sweep_wrap_k%0d", k), wrap_s, (k % 8 == 0));
        end
        chk("sweep_valid", valid_s, 4'hf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter: CH, default 2, number of independent mux channels (1..8).
REQ-002 Parameter: SEL_W, default 2, select width; each channel has 2**SEL_W inputs.
REQ-003 Parameter: DW, default 1, data width per input (1..32).
REQ-004 Parameter: DWELL, default 4, cycles each input is held in scan mode (1..255).
REQ-005 Port: clk  input  1  sole clock, rising edge.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: en_n  input  CH  per-channel enable, active-low.
REQ-008 Port: mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 Port: sel  input  SEL_W  manual select index.
REQ-010 Port: din  input  CH*(2**SEL_W)*DW  flattened inputs; channel c, input i occupies bits [(c*2**SEL_W+i)*DW +: DW].
REQ-011 Port: dout  output  CH*DW  registered outputs; channel c at [c*DW +: DW].
REQ-012 Port: valid  output  CH  registered; bit c high when dout for channel c carries selected data.
REQ-013 Port: cur_sel  output  SEL_W  registered index used for the current dout.
REQ-014 Port: scan_wrap  output  1  one-cycle pulse when the scan index wraps to 0.

Function
REQ-015 Exactly three FSM states SHALL exist: MANUAL, SCAN and PAUSE.
REQ-016 MANUAL -> SCAN on mode=1 with at least one en_n bit low; MANUAL -> PAUSE on mode=1 with all en_n high.
REQ-017 SCAN -> PAUSE when all en_n bits are high; PAUSE -> SCAN when any en_n bit is low and mode=1.
REQ-018 SCAN or PAUSE -> MANUAL on mode=0, taking effect on the next clock edge.
REQ-019 Entering SCAN from MANUAL SHALL clear the scan index and dwell counter to 0; entering SCAN from PAUSE SHALL resume both counters from their held values.
REQ-020 In SCAN the dwell counter counts 0..DWELL-1; at DWELL-1 it clears and the index increments.
REQ-021 Index wraps from 2**SEL_W-1 to 0; scan_wrap is high for exactly the cycle after the wrap edge.
REQ-022 In PAUSE both counters hold, scan_wrap stays 0, and dout/valid follow REQ-025.
REQ-023 Effective index: sel in MANUAL, scan index in SCAN/PAUSE; cur_sel registers the effective index.
REQ-024 Latency: one clock; dout[c] and valid[c] at edge N reflect din, en_n and effective index sampled at edge N.
REQ-025 Enabled channel (en_n[c]=0): dout[c] <= selected input, valid[c] <= 1; disabled channel: valid[c] <= 0, dout[c] per REQ-030/031.
REQ-026 Channels SHALL be fully independent; multiple enabled channels all update (no priority between channels).
REQ-027 DWELL=1 SHALL advance the index every cycle; CH=1 and SEL_W=1 SHALL be legal.

Reset
REQ-028 While rst_n is low: FSM = MANUAL, scan index = 0, dwell counter = 0, dout = 0, valid = 0, cur_sel = 0, scan_wrap = 0.
REQ-029 Reset asserted mid-scan SHALL abort immediately; after release the FSM starts in MANUAL with counters at 0 regardless of the prior state.

Configuration
REQ-030 Macro SCAN_MUX_HOLD_EN defined: a disabled channel's dout SHALL hold its last value.
REQ-031 SCAN_MUX_HOLD_EN undefined: a disabled channel's dout SHALL be driven to 0 on the next edge; valid behaviour is identical in both builds.

Verification
REQ-032 Defaults, manual: mode=0, en_n=2'b00, sel=2, ch0 inputs {0,0,1,0}, ch1 inputs {1,1,0,1} -> one cycle later dout=2'b01, valid=2'b11, cur_sel=2.
REQ-033 Scan: mode 0->1, en_n=2'b10, DWELL=4 -> cur_sel steps 0,1,2,3 every 4 cycles; scan_wrap pulses once after 16 cycles; valid=2'b01.
REQ-034 Pause/resume: during scan at index 2, dwell count 1, set en_n=2'b11 for 5 cycles, then 2'b00 -> cur_sel holds 2; after resume, 3 more cycles at index 2, then 3.
REQ-035 Disable behaviour: ch0 enabled and dout[0]=1, then en_n[0]=1 -> without SCAN_MUX_HOLD_EN dout[0]=0; with it dout[0]=1; valid[0]=0 in both.
REQ-036 Reset mid-scan: rst_n low at index 3 without a clock edge -> outputs immediately 0; after release with mode=0, sel=1 -> cur_sel=1 after one edge.
REQ-037 Parameter sweep: CH=4, SEL_W=3, DW=8, DWELL=1, all enabled, din[c][i]=c*16+i -> in scan, dout ch3 sequences 0x30..0x37, scan_wrap every 8 cycles.
